// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - APB signal bundle shared by the upstream and downstream ports
interface apb_master_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-master round-robin APB arbiter with wait-state timeout
module apb_master_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                 PCLK,
   input  logic                 PRESETN,
   apb_master_arbiter_if.slave  m0,
   apb_master_arbiter_if.slave  m1,
   apb_master_arbiter_if.master apb,
   output logic [1:0]           GNT
);
   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              last_gnt_q, last_gnt_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [1:0]        pready_q, pready_d;
   logic [1:0]        pslverr_q, pslverr_d;
   logic [DATA_W-1:0] prdata0_q, prdata0_d;
   logic [DATA_W-1:0] prdata1_q, prdata1_d;

   logic              win;
   logic              resp_en;
   logic              resp_err;
   logic [DATA_W-1:0] resp_data;

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      gnt_d      = gnt_q;
      wait_cnt_d = wait_cnt_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      pwrite_d   = pwrite_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      pready_d   = 2'b00;
      pslverr_d  = 2'b00;
      prdata0_d  = prdata0_q;
      prdata1_d  = prdata1_q;
      resp_en    = 1'b0;
      resp_err   = 1'b0;
      resp_data  = '0;
      // On contention the master that did not win last time gets the bus
      win        = (m0.PSEL && m1.PSEL) ? ~last_gnt_q : m1.PSEL;

      case (state_q)
         S_IDLE: begin
            if (m0.PSEL || m1.PSEL) begin
               state_d    = S_SETUP;
               last_gnt_d = win;
               gnt_d      = win ? 2'b10 : 2'b01;
               psel_d     = 1'b1;
               penable_d  = 1'b0;
               pwrite_d   = win ? m1.PWRITE : m0.PWRITE;
               paddr_d    = win ? m1.PADDR  : m0.PADDR;
               pwdata_d   = win ? m1.PWDATA : m0.PWDATA;
            end
         end
         S_SETUP: begin
            state_d    = S_ACCESS;
            penable_d  = 1'b1;
            wait_cnt_d = '0;
         end
         S_ACCESS: begin
            if (apb.PREADY) begin
               resp_en   = 1'b1;
               resp_data = apb.PRDATA;
               resp_err  = apb.PSLVERR;
            end else if (wait_cnt_q == CNT_LAST) begin
               resp_en    = 1'b1;
               resp_err   = 1'b1;
               wait_cnt_d = CNT_MAX;
            end else if (wait_cnt_q != CNT_MAX) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            gnt_d   = 2'b00;
         end
         default: state_d = S_IDLE;
      endcase

      // Completion and abort share one path; only the granted master's registers move
      if (resp_en) begin
         state_d   = S_RESP;
         psel_d    = 1'b0;
         penable_d = 1'b0;
         pready_d  = gnt_q;
         pslverr_d = resp_err ? gnt_q : 2'b00;
         if (gnt_q[1]) prdata1_d = resp_data;
         else          prdata0_d = resp_data;
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETN) begin
         state_q    <= S_IDLE;
         last_gnt_q <= 1'b1;
         gnt_q      <= 2'b00;
         wait_cnt_q <= '0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         pready_q   <= 2'b00;
         pslverr_q  <= 2'b00;
         prdata0_q  <= '0;
         prdata1_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         gnt_q      <= gnt_d;
         wait_cnt_q <= wait_cnt_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         pwrite_q   <= pwrite_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
         prdata0_q  <= prdata0_d;
         prdata1_q  <= prdata1_d;
      end
   end

   assign apb.PSEL    = psel_q;
   assign apb.PENABLE = penable_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PADDR   = paddr_q;
   assign apb.PWDATA  = pwdata_q;
   assign m0.PREADY   = pready_q[0];
   assign m0.PSLVERR  = pslverr_q[0];
   assign m0.PRDATA   = prdata0_q;
   assign m1.PREADY   = pready_q[1];
   assign m1.PSLVERR  = pslverr_q[1];
   assign m1.PRDATA   = prdata1_q;
   assign GNT         = gnt_q;

   // Upstream PENABLE carries no information the arbiter needs
   logic unused_penable;
   assign unused_penable = m0.PENABLE ^ m1.PENABLE;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;
   localparam int TO = 8;

   logic       PCLK = 1'b0;
   logic       PRESETN = 1'b0;
   logic [1:0] GNT;
   int         total_cnt = 0;
   int         pass_cnt  = 0;

   apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
   apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
   apb_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

   apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESETN(PRESETN), .m0(m0_if), .m1(m1_if), .apb(s_if), .GNT(GNT)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1);
   end

   typedef struct {
      int          m;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] rdata;
      bit          serr;
      int          exp_lat;
      logic [31:0] exp_prdata;
      bit          exp_serr;
   } vec_t;
   vec_t vecs [5];

   // Reference model: transfer owner plus cycle age since grant
   int          mo_owner, mo_age, mo_last;
   bit          mo_resp, mo_serr, mo_wr;
   logic [31:0] mo_addr, mo_wdata;
   logic [31:0] mo_prdata [2];

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic set_master(input int m, input bit sel, input bit wr, input logic [31:0] a, input logic [31:0] d);
      if (m == 0) begin
         m0_if.PSEL = sel; m0_if.PENABLE = 1'b0; m0_if.PWRITE = wr; m0_if.PADDR = a; m0_if.PWDATA = d;
      end else begin
         m1_if.PSEL = sel; m1_if.PENABLE = 1'b0; m1_if.PWRITE = wr; m1_if.PADDR = a; m1_if.PWDATA = d;
      end
   endtask

   function automatic logic get_pready(input int m);
      return (m == 0) ? m0_if.PREADY : m1_if.PREADY;
   endfunction

   function automatic logic get_pslverr(input int m);
      return (m == 0) ? m0_if.PSLVERR : m1_if.PSLVERR;
   endfunction

   function automatic logic [31:0] get_prdata(input int m);
      return (m == 0) ? m0_if.PRDATA : m1_if.PRDATA;
   endfunction

   function automatic logic [191:0] dut_vec();
      logic [191:0] v = '0;
      v[136:0] = {GNT, s_if.PSEL, s_if.PENABLE, s_if.PWRITE, s_if.PADDR, s_if.PWDATA,
                  m0_if.PREADY, m0_if.PSLVERR, m0_if.PRDATA, m1_if.PREADY, m1_if.PSLVERR, m1_if.PRDATA};
      return v;
   endfunction

   function automatic logic [191:0] model_vec();
      logic [191:0] v = '0;
      logic [1:0]   g = (mo_owner < 0) ? 2'b00 : ((mo_owner == 1) ? 2'b10 : 2'b01);
      bit ps  = (mo_owner >= 0) && !mo_resp;
      bit pe  = ps && (mo_age >= 2);
      bit r0  = mo_resp && (mo_owner == 0);
      bit r1  = mo_resp && (mo_owner == 1);
      v[136:0] = {g, ps, pe, mo_wr, mo_addr, mo_wdata,
                  r0, r0 && mo_serr, mo_prdata[0], r1, r1 && mo_serr, mo_prdata[1]};
      return v;
   endfunction

   // Advance the model across one edge using the inputs that were just sampled
   task automatic model_edge();
      int k;
      if (!PRESETN) begin
         mo_owner = -1; mo_age = 0; mo_resp = 0; mo_last = 1; mo_serr = 0;
         mo_wr = 0; mo_addr = '0; mo_wdata = '0; mo_prdata[0] = '0; mo_prdata[1] = '0;
      end else if (mo_resp) begin
         mo_resp = 0; mo_owner = -1;
      end else if (mo_owner < 0) begin
         if (m0_if.PSEL || m1_if.PSEL) begin
            mo_owner = (m0_if.PSEL && m1_if.PSEL) ? 1 - mo_last : (m1_if.PSEL ? 1 : 0);
            mo_last  = mo_owner;
            mo_age   = 1;
            mo_wr    = (mo_owner == 1) ? m1_if.PWRITE : m0_if.PWRITE;
            mo_addr  = (mo_owner == 1) ? m1_if.PADDR  : m0_if.PADDR;
            mo_wdata = (mo_owner == 1) ? m1_if.PWDATA : m0_if.PWDATA;
         end
      end else if (mo_age == 1) begin
         mo_age = 2;
      end else begin
         k = mo_age - 1;
         if (s_if.PREADY) begin
            mo_resp = 1; mo_serr = s_if.PSLVERR; mo_prdata[mo_owner] = s_if.PRDATA;
         end else if (k == TO) begin
            mo_resp = 1; mo_serr = 1; mo_prdata[mo_owner] = '0;
         end else begin
            mo_age++;
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat = 0, acc = 0, psel_at = 0, pen_at = 0, psel_cycles = 0;
      bit other_rdy = 0, addr_bad = 0, serr_early = 0, pen_bad = 0, gnt_bad = 0;
      bit rdy;
      string tag = $sformatf("vec%0d", idx);
      set_master(v.m, 1, v.wr, v.addr, v.wdata);
      while (lat < 40) begin
         step();
         lat++;
         if (s_if.PSEL && psel_at == 0) psel_at = lat;
         if (s_if.PENABLE && pen_at == 0) pen_at = lat;
         if (s_if.PENABLE && !s_if.PSEL) pen_bad = 1;
         if (s_if.PSEL) begin
            psel_cycles++;
            if (s_if.PADDR !== v.addr || s_if.PWDATA !== v.wdata || s_if.PWRITE !== v.wr) addr_bad = 1;
            if (GNT !== (2'b01 << v.m)) gnt_bad = 1;
         end
         if (get_pready(1 - v.m)) other_rdy = 1;
         if (get_pready(v.m)) break;
         if (get_pslverr(v.m)) serr_early = 1;
         // Upstream changes while the transfer is in flight must not reach the bus
         set_master(v.m, 1, ~v.wr, ~v.addr, ~v.wdata);
         if (s_if.PSEL && s_if.PENABLE) acc++;
         rdy = s_if.PSEL && s_if.PENABLE && (acc > v.waits);
         s_if.PREADY  = rdy;
         s_if.PRDATA  = rdy ? v.rdata : (32'hBAD0_0000 | 32'(acc));
         s_if.PSLVERR = rdy ? v.serr : ~v.serr;
      end
      chk({tag, "_latency"}, lat, v.exp_lat);
      chk({tag, "_psel_at"}, psel_at, 1);
      chk({tag, "_penable_at"}, pen_at, 2);
      chk({tag, "_psel_cycles"}, psel_cycles, v.exp_lat - 1);
      chk({tag, "_prdata"}, get_prdata(v.m), v.exp_prdata);
      chk({tag, "_pslverr"}, get_pslverr(v.m), v.exp_serr);
      chk({tag, "_gnt_resp"}, GNT, 2'b01 << v.m);
      chk({tag, "_flags"}, {other_rdy, addr_bad, serr_early, pen_bad, gnt_bad}, 5'b0);
      set_master(v.m, 0, 0, '0, '0);
      s_if.PREADY = 0; s_if.PSLVERR = 0;
      step();
      chk({tag, "_after_resp"}, {get_pready(v.m), get_pslverr(v.m), GNT, get_prdata(v.m)},
          {1'b0, 1'b0, 2'b00, v.exp_prdata});
   endtask

   initial begin
      int order[$];
      int first, n;
      bit dbl, gbad, prev0, prev1, d0, d1, seen;
      bit act [2];
      bit prv [2];
      bit stall;

      vecs[0] = '{m:0, wr:1, addr:32'h0000_0104, wdata:32'hDEAD_BEEF, waits:0,  rdata:32'h0000_0000, serr:0, exp_lat:3,  exp_prdata:32'h0000_0000, exp_serr:0};
      vecs[1] = '{m:1, wr:0, addr:32'h0000_2000, wdata:32'h0000_0011, waits:4,  rdata:32'h1234_5678, serr:0, exp_lat:7,  exp_prdata:32'h1234_5678, exp_serr:0};
      vecs[2] = '{m:0, wr:0, addr:32'h0000_3000, wdata:32'h0000_0022, waits:99, rdata:32'hA5A5_A5A5, serr:0, exp_lat:10, exp_prdata:32'h0000_0000, exp_serr:1};
      vecs[3] = '{m:1, wr:1, addr:32'h0000_4000, wdata:32'h0000_0033, waits:0,  rdata:32'h0F0F_0F0F, serr:1, exp_lat:3,  exp_prdata:32'h0F0F_0F0F, exp_serr:1};
      vecs[4] = '{m:0, wr:0, addr:32'h0000_5000, wdata:32'h0000_0044, waits:7,  rdata:32'hCAFE_F00D, serr:0, exp_lat:10, exp_prdata:32'hCAFE_F00D, exp_serr:0};

      set_master(0, 0, 0, '0, '0);
      set_master(1, 0, 0, '0, '0);
      s_if.PREADY = 0; s_if.PRDATA = '0; s_if.PSLVERR = 0;
      PRESETN = 0;
      step(); step();
      chk("reset_state", dut_vec(), '0);
      PRESETN = 1;
      step();

      // Simultaneous requests right after reset alternate M0, M1
      dbl = 0; gbad = 0; prev0 = 0; prev1 = 0;
      s_if.PREADY = 1;
      for (int r = 0; r < 3; r++) begin
         d0 = 0; d1 = 0; n = 0;
         set_master(0, 1, 1, 32'h1000 + 32'(r), 32'(r));
         set_master(1, 1, 0, 32'h2000 + 32'(r), 32'(r));
         while (!(d0 && d1) && n < 30) begin
            step(); n++;
            if ((m0_if.PREADY && prev0) || (m1_if.PREADY && prev1)) dbl = 1;
            prev0 = m0_if.PREADY; prev1 = m1_if.PREADY;
            if (m0_if.PREADY) begin order.push_back(0); d0 = 1; set_master(0, 0, 0, '0, '0); if (GNT !== 2'b01) gbad = 1; end
            if (m1_if.PREADY) begin order.push_back(1); d1 = 1; set_master(1, 0, 0, '0, '0); if (GNT !== 2'b10) gbad = 1; end
         end
         step();
         prev0 = m0_if.PREADY; prev1 = m1_if.PREADY;
      end
      for (int i = 0; i < 6; i++)
         chk($sformatf("grant_order_%0d", i), (i < order.size()) ? order[i] : 9, i % 2);
      chk("pready_single_cycle", dbl, 0);
      chk("gnt_during_resp", gbad, 0);
      s_if.PREADY = 0;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // Reset in ACCESS after an M0 grant, then contention must again favour M0
      set_master(0, 1, 1, 32'h0000_0300, 32'h0000_0077);
      s_if.PREADY = 0;
      n = 0;
      while (!(s_if.PSEL && s_if.PENABLE) && n < 10) begin step(); n++; end
      chk("rst_reach_access", s_if.PSEL && s_if.PENABLE, 1);
      PRESETN = 0;
      step();
      chk("rst_mid_outputs", dut_vec(), '0);
      PRESETN = 1;
      set_master(0, 0, 0, '0, '0);
      seen = 0;
      for (int i = 0; i < 5; i++) begin step(); if (m0_if.PREADY || m1_if.PREADY) seen = 1; end
      chk("rst_no_pready", seen, 0);
      set_master(0, 1, 0, 32'h0000_0600, '0);
      set_master(1, 1, 0, 32'h0000_0700, '0);
      s_if.PREADY = 1;
      first = 9; n = 0;
      while (first == 9 && n < 20) begin
         step(); n++;
         if (m0_if.PREADY) first = 0;
         else if (m1_if.PREADY) first = 1;
      end
      chk("post_reset_winner", first, 0);
      set_master(0, 0, 0, '0, '0);
      set_master(1, 0, 0, '0, '0);
      s_if.PREADY = 0;
      step(); step();

      // Randomised traffic against the reference model
      PRESETN = 0;
      act[0] = 0; act[1] = 0; prv[0] = 0; prv[1] = 0; stall = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         step();
         model_edge();
         chk($sformatf("rand_cycle_%0d", cyc), dut_vec(), model_vec());
         for (int m = 0; m < 2; m++) begin
            if (!PRESETN) act[m] = 0;
            else if (act[m] && prv[m]) act[m] = 0;
            if (!act[m]) begin
               if ($urandom_range(0, 2) == 0) begin
                  act[m] = 1;
                  set_master(m, 1, 1'($urandom_range(0, 1)), $urandom, $urandom);
               end else begin
                  set_master(m, 0, 0, $urandom, $urandom);
               end
            end
            prv[m] = get_pready(m);
         end
         if (s_if.PSEL && !s_if.PENABLE) stall = ($urandom_range(0, 5) == 0);
         s_if.PREADY  = stall ? 1'b0 : 1'($urandom_range(0, 1));
         s_if.PRDATA  = $urandom;
         s_if.PSLVERR = 1'($urandom_range(0, 1));
         PRESETN = ($urandom_range(0, 149) != 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, downstream and upstream address width.
REQ-002 SHALL have parameter DATA_W, default 32, read and write data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of ACCESS cycles with PREADY low before an abort (range 1..65535).
REQ-004 SHALL have port PCLK, input, 1 bit, the single clock.
REQ-005 SHALL have port PRESETN, input, 1 bit, a synchronous active-low reset.
REQ-006 SHALL have the following upstream ports for master m (m = 0, 1): Mm_PSEL, Mm_PENABLE, Mm_PWRITE (inputs, 1 bit each); Mm_PADDR (input, ADDR_W); Mm_PWDATA (input, DATA_W).
REQ-007 SHALL have the following upstream response ports for master m: Mm_PRDATA (output, DATA_W); Mm_PREADY and Mm_PSLVERR (outputs, 1 bit each).
REQ-008 SHALL have the downstream APB master port, which drives the interconnect: PSEL, PENABLE, PWRITE (outputs, 1 bit each); PADDR (output, ADDR_W); PWDATA (output, DATA_W).
REQ-009 SHALL have the downstream response inputs PRDATA (DATA_W), PREADY (1 bit) and PSLVERR (1 bit).
REQ-010 SHALL have output GNT, 2 bits, one-hot indication of the master owning the current transfer; 00 when IDLE.

Function
REQ-011 SHALL implement an FSM with states IDLE, SETUP, ACCESS and RESP, with all outputs registered.
REQ-012 IDLE: a master is requesting when its Mm_PSEL=1.
- If at least one master requests, the FSM SHALL latch the winner's PADDR, PWRITE and PWDATA, set GNT, and go to SETUP.
- Otherwise the FSM SHALL stay in IDLE.
REQ-013 Arbitration SHALL be round-robin using register last_gnt.
- With a single requester, that requester wins.
- With both requesting, the master not equal to last_gnt wins.
- last_gnt SHALL update on entry to SETUP.
REQ-014 SETUP: the block SHALL drive PSEL=1 and PENABLE=0 for exactly one cycle, then go to ACCESS.
REQ-015 ACCESS: the block SHALL drive PSEL=1 and PENABLE=1 and increment a wait counter each cycle PREADY=0.
REQ-016 ACCESS with PREADY=1 sampled: the block SHALL capture PRDATA and PSLVERR into the winner's response registers, drop PSEL and PENABLE, and go to RESP.
REQ-017 ACCESS when the wait counter reaches TIMEOUT with PREADY still 0: the block SHALL abort, drop PSEL and PENABLE, set the response to PRDATA=0 and PSLVERR=1, and go to RESP.
REQ-018 RESP: the block SHALL assert Mm_PREADY=1 for the granted master only, for exactly one cycle, with Mm_PRDATA and Mm_PSLVERR valid, then go to IDLE with GNT=00.
REQ-019 The non-granted master's Mm_PREADY SHALL be 0 in every state, which stalls it per APB wait-state rules; that master must hold its signals.
REQ-020 Mm_PRDATA SHALL hold its last value outside RESP.
REQ-021 Mm_PSLVERR SHALL be 0 outside RESP.
REQ-022 Zero-wait-state latency: with Mm_PSEL first sampled high in IDLE at edge t, SETUP occupies t+1, ACCESS t+2, and Mm_PREADY=1 occurs in cycle t+3.
REQ-023 The downstream PADDR, PWRITE and PWDATA SHALL be stable from SETUP through the end of ACCESS; upstream changes during a transfer SHALL be ignored.
REQ-024 The downstream PENABLE SHALL never be 1 while PSEL is 0.
REQ-025 The downstream PSEL SHALL never stay high for more than TIMEOUT+1 cycles per transfer.
REQ-026 A request arriving while the FSM is not in IDLE SHALL be serviced only after the return to IDLE; there is no bus preemption.
REQ-027 A master's PSEL high in the IDLE cycle immediately following its RESP SHALL be treated as a new transfer.
REQ-028 The wait counter SHALL be ceil(log2(TIMEOUT+1)) bits wide, SHALL clear on entry to ACCESS, and SHALL saturate rather than wrap.

Reset
REQ-029 With PRESETN=0 sampled, the block SHALL set FSM=IDLE and last_gnt=1 (so M0 wins the first contention).
REQ-030 With PRESETN=0 sampled, the block SHALL clear the wait counter, PSEL, PENABLE, PWRITE, PADDR, PWDATA, GNT and every Mm_PREADY, Mm_PSLVERR and Mm_PRDATA to 0.
REQ-031 A reset asserted mid-transfer SHALL deassert PSEL and PENABLE on the next edge and SHALL issue no upstream Mm_PREADY for the aborted transfer.

Verification
REQ-032 Single M0 write, with PADDR=0x0000_0104, PWDATA=0xDEAD_BEEF and a zero-wait slave -> downstream PSEL at t+1, PENABLE at t+2, M0_PREADY=1 at t+3, GNT=01 during the transfer.
REQ-033 M0 and M1 both assert PSEL in the same cycle after reset, repeated three times -> grants M0, M1, M0, M1, M0, M1; each master's PREADY pulses are exactly 1 cycle long.
REQ-034 M1 read where the slave inserts 4 wait states then returns PRDATA=0x1234_5678 and PSLVERR=0 -> M1_PRDATA=0x1234_5678 with M1_PREADY in the cycle after downstream PREADY; M0_PREADY stays 0 throughout.
REQ-035 TIMEOUT=8 and the slave never asserts PREADY -> PSEL drops after 8 ACCESS cycles, and M0 sees PREADY=1, PSLVERR=1, PRDATA=0.
REQ-036 Slave returns PSLVERR=1 with PREADY=1 -> the granted master sees PSLVERR=1 only during its RESP cycle.
REQ-037 PRESETN driven low during ACCESS -> all outputs are 0 at the next edge, no Mm_PREADY pulse occurs, and the next contention after release is won by M0.
